// File: rtl/axi_link_bringup_seq.sv
// axi_link_bringup_seq: link bring-up sequencer (align -> rx online -> tx online) with timeout, backoff and retry limit.
module axi_link_bringup_seq #(
  parameter int DELAY_WIDTH = 16,
  parameter int RETRY_WIDTH = 4
) (
  input  logic                   clk_wr,
  input  logic                   rst_wr,
  input  logic                   phy_ready,
  input  logic                   align_done,
  input  logic                   link_lost,
  input  logic                   clr_fail,
  input  logic [DELAY_WIDTH-1:0] delay_x_value,
  input  logic [DELAY_WIDTH-1:0] delay_y_value,
  input  logic [DELAY_WIDTH-1:0] delay_z_value,
  input  logic [RETRY_WIDTH-1:0] max_retry,
  output logic                   rx_online,
  output logic                   tx_online,
  output logic                   link_up,
  output logic                   link_fail,
  output logic [2:0]             state,
  output logic [RETRY_WIDTH-1:0] retry_cnt
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, WAIT_ALIGN = 3'd1, DLY_X = 3'd2, DLY_Y = 3'd3,
    ONLINE = 3'd4, BACKOFF = 3'd5, FAIL = 3'd6, BAD = 3'd7
  } state_t;
  state_t                 state_q, state_d;
  logic [DELAY_WIDTH-1:0] cnt_q, dly_q, dly_d;
  logic [RETRY_WIDTH-1:0] retry_q, retry_d;
  logic                   rx_q, tx_q, up_q, fail_q;
  logic                   done, lost, chg;
  // A zero delay behaves as one cycle; the counter saturates at its terminal value.
  assign done = (dly_q == '0) || (cnt_q == dly_q - 1'b1);
  assign lost = !phy_ready || link_lost;
  assign chg  = state_d != state_q;
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:       state_d = phy_ready ? WAIT_ALIGN : IDLE;
      WAIT_ALIGN: state_d = !phy_ready ? IDLE : align_done ? DLY_X :
                            (dly_q != '0 && done) ? BACKOFF : WAIT_ALIGN;
      DLY_X:      state_d = lost ? BACKOFF : done ? DLY_Y : DLY_X;
      DLY_Y:      state_d = lost ? BACKOFF : done ? ONLINE : DLY_Y;
      ONLINE:     state_d = lost ? BACKOFF : ONLINE;
      BACKOFF:    state_d = !done ? BACKOFF :
                            (max_retry != '0 && retry_q >= max_retry) ? FAIL : IDLE;
      FAIL:       state_d = clr_fail ? IDLE : FAIL;
      default:    state_d = IDLE;
    endcase
  end
  assign dly_d   = state_d == DLY_X ? delay_x_value : state_d == DLY_Y ? delay_y_value : delay_z_value;
  assign retry_d = (chg && state_d == BACKOFF) ? (&retry_q ? retry_q : retry_q + 1'b1) :
                   (chg && (state_d == ONLINE || state_q == FAIL)) ? '0 : retry_q;
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dly_q   <= '0;
      retry_q <= '0;
      rx_q    <= 1'b0;
      tx_q    <= 1'b0;
      up_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= chg ? '0 : done ? cnt_q : cnt_q + 1'b1;
      dly_q   <= chg ? dly_d : dly_q;
      retry_q <= retry_d;
      rx_q    <= state_d == DLY_Y || state_d == ONLINE;
      tx_q    <= state_d == ONLINE;
      up_q    <= state_d == ONLINE;
      fail_q  <= state_d == FAIL;
    end
  end
  assign rx_online = rx_q;
  assign tx_online = tx_q;
  assign link_up   = up_q;
  assign link_fail = fail_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;
endmodule

// File: tb/tb_axi_link_bringup_seq.sv
// tb_axi_link_bringup_seq: directed bring-up, timeout, link-loss, zero-delay and async-reset scenarios.
module tb_axi_link_bringup_seq;
  logic        clk_wr = 1'b0;
  logic        rst_wr = 1'b0;
  logic        phy_ready = 1'b0, align_done = 1'b0, link_lost = 1'b0, clr_fail = 1'b0;
  logic [15:0] delay_x_value = 16'd4, delay_y_value = 16'd3, delay_z_value = 16'd10;
  logic [3:0]  max_retry = 4'd2;
  logic        rx_online, tx_online, link_up, link_fail;
  logic [2:0]  state;
  logic [3:0]  retry_cnt;
  int          errors = 0;
  int          checks = 0;
  axi_link_bringup_seq dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .phy_ready(phy_ready), .align_done(align_done),
    .link_lost(link_lost), .clr_fail(clr_fail), .delay_x_value(delay_x_value),
    .delay_y_value(delay_y_value), .delay_z_value(delay_z_value), .max_retry(max_retry),
    .rx_online(rx_online), .tx_online(tx_online), .link_up(link_up), .link_fail(link_fail),
    .state(state), .retry_cnt(retry_cnt)
  );
  always #5 clk_wr = ~clk_wr;
  task automatic tick(input int n);
    repeat (n) @(posedge clk_wr);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    #1 rst_wr = 1'b1;
    tick(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_retry", 32'(retry_cnt), 0);
    chk("rst_outs", 32'({rx_online, tx_online, link_up, link_fail}), 0);
    rst_wr = 1'b0;
    phy_ready = 1'b1;
    tick(1);
    chk("bring_wait_align", 32'(state), 1);
    tick(4);
    chk("bring_still_wait", 32'(state), 1);
    align_done = 1'b1;
    tick(1);
    chk("bring_dly_x", 32'(state), 2);
    align_done = 1'b0;
    tick(3);
    chk("bring_dly_x_end", 32'({state, rx_online}), {3'd2, 1'b0});
    tick(1);
    chk("bring_rx_on", 32'({state, rx_online, tx_online}), {3'd3, 1'b1, 1'b0});
    delay_y_value = 16'd1;
    tick(2);
    chk("bring_y_captured", 32'({state, tx_online}), {3'd3, 1'b0});
    delay_y_value = 16'd3;
    tick(1);
    chk("bring_online", 32'({state, tx_online, link_up}), {3'd4, 1'b1, 1'b1});
    chk("bring_retry", 32'(retry_cnt), 0);
    link_lost = 1'b1;
    tick(1);
    link_lost = 1'b0;
    chk("loss_backoff", 32'({state, rx_online, tx_online, link_up}), {3'd5, 3'b000});
    chk("loss_retry", 32'(retry_cnt), 1);
    tick(9);
    chk("loss_backoff_len", 32'(state), 5);
    tick(1);
    chk("loss_idle", 32'(state), 0);
    align_done = 1'b1;
    tick(2);
    chk("retrain_dly_x", 32'(state), 2);
    tick(4);
    tick(3);
    chk("retrain_online", 32'({state, retry_cnt}), {3'd4, 4'd0});
    link_lost = 1'b1;
    tick(1);
    link_lost = 1'b0;
    tick(10);
    chk("loss2_idle", 32'({state, retry_cnt}), {3'd0, 4'd1});
    tick(6);
    chk("late_dly_y", 32'({state, rx_online}), {3'd3, 1'b1});
    tick(2);
    phy_ready = 1'b0;
    tick(1);
    chk("late_drop_backoff", 32'({state, tx_online, rx_online}), {3'd5, 2'b00});
    chk("late_drop_retry", 32'(retry_cnt), 2);
    tick(9);
    chk("late_backoff_len", 32'({state, tx_online}), {3'd5, 1'b0});
    tick(1);
    chk("fail_enter", 32'({state, link_fail, tx_online, rx_online}), {3'd6, 3'b100});
    tick(3);
    chk("fail_sticky", 32'({state, link_fail}), {3'd6, 1'b1});
    clr_fail = 1'b1;
    tick(1);
    clr_fail = 1'b0;
    chk("fail_clear", 32'({state, retry_cnt, link_fail}), {3'd0, 4'd0, 1'b0});
    align_done = 1'b0;
    phy_ready = 1'b1;
    tick(1);
    chk("to_wait_align", 32'(state), 1);
    clr_fail = 1'b1;
    tick(1);
    clr_fail = 1'b0;
    chk("clr_ignored", 32'(state), 1);
    tick(8);
    chk("to_wait_len", 32'(state), 1);
    tick(1);
    chk("to_backoff1", 32'({state, retry_cnt}), {3'd5, 4'd1});
    tick(10);
    chk("to_idle", 32'(state), 0);
    tick(11);
    chk("to_backoff2", 32'({state, retry_cnt}), {3'd5, 4'd2});
    tick(10);
    chk("to_fail", 32'({state, link_fail}), {3'd6, 1'b1});
    clr_fail = 1'b1;
    tick(1);
    clr_fail = 1'b0;
    chk("to_clear", 32'({state, retry_cnt}), {3'd0, 4'd0});
    tick(11);
    chk("wa_drop_setup", 32'({state, retry_cnt}), {3'd5, 4'd1});
    tick(11);
    chk("wa_drop_in_wa", 32'(state), 1);
    phy_ready = 1'b0;
    tick(1);
    chk("wa_drop_idle", 32'({state, retry_cnt}), {3'd0, 4'd1});
    delay_x_value = '0;
    delay_y_value = '0;
    delay_z_value = '0;
    max_retry = '0;
    phy_ready = 1'b1;
    tick(1);
    tick(30);
    chk("zero_no_timeout", 32'(state), 1);
    align_done = 1'b1;
    tick(1);
    chk("zero_dly_x", 32'(state), 2);
    tick(1);
    chk("zero_dly_y", 32'({state, rx_online}), {3'd3, 1'b1});
    tick(1);
    chk("zero_online", 32'({state, tx_online, retry_cnt}), {3'd4, 1'b1, 4'd0});
    link_lost = 1'b1;
    tick(80);
    chk("sat_retry", 32'(retry_cnt), 15);
    chk("sat_no_fail", 32'({state, link_fail}), {3'd2, 1'b0});
    link_lost = 1'b0;
    tick(2);
    chk("sat_reonline", 32'({state, retry_cnt}), {3'd4, 4'd0});
    #3 rst_wr = 1'b1;
    #1;
    chk("arst_outs", 32'({rx_online, tx_online, link_up, link_fail}), 0);
    chk("arst_state", 32'({state, retry_cnt}), 0);
    tick(1);
    rst_wr = 1'b0;
    tick(1);
    chk("arst_restart", 32'(state), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
